// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and defaults for the KLP32V2 MMIO bus arbiter.
package mmio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mmio_req_t;

    localparam int          DEF_TIMEOUT_CYCLES = 16;
    localparam logic [31:0] DEF_ERR_DATA       = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_MMIO_BASE      = 32'h1000_0000;
    localparam logic [31:0] DEF_MMIO_MASK      = 32'hF000_0000;

    // True when addr falls inside the MMIO window described by base/mask.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of the two master request channels and the MMIO slave bus.
// The master modport is the arbiter's view; the slave modport is the
// environment (masters plus MMIO slave) view.
interface mmio_bus_arbiter_if;

    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_ack;
    logic [31:0] m0_rdata;
    logic        m0_err;
    logic        m0_stall;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_ack;
    logic [31:0] m1_rdata;
    logic        m1_err;

    logic [31:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_cs;
    logic        bus_wr;
    logic        bus_rd;
    logic        bus_ready;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err, m0_stall,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output bus_addr, bus_wr_data, bus_cs, bus_wr, bus_rd,
        input  bus_rd_data, bus_ready
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err, m0_stall,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  bus_addr, bus_wr_data, bus_cs, bus_wr, bus_rd,
        output bus_rd_data, bus_ready
    );

endinterface

// File: rtl/mmio_bus_arbiter_picker.sv
// Two-requester grant selection for the MMIO arbiter.
// MMIO_ARB_RR_EN defined: round-robin with a last-grant pointer (resets to m1).
// MMIO_ARB_RR_EN undefined: fixed priority, m0 wins, no pointer state.
module mmio_rr_picker (
`ifdef MMIO_ARB_RR_EN
    input  logic clk,
    input  logic reset,
    input  logic take,
`endif
    input  logic req0,
    input  logic req1,
    output logic pick,
    output logic valid
);

`ifdef MMIO_ARB_RR_EN
    logic last;

    // Winner selection: on contention the master not granted last wins.
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            pick = ~last;
        end else begin
            pick = ~req0;
        end
    end

    // Pointer follows every grant the arbiter actually takes.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (take) begin
            last <= pick;
        end
    end
`else
    // Fixed priority: m0 wins whenever it requests.
    always_comb begin
        valid = req0 | req1;
        pick  = ~req0;
    end
`endif

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master arbiter/sequencer for the KLP32V2 MMIO bus.
// IDLE -> BUSY -> RESP -> IDLE; out-of-window requests skip BUSY.
// All outputs registered except m0_stall. Optional macro: MMIO_ARB_RR_EN.
module mmio_bus_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA,
    parameter logic [31:0] MMIO_BASE      = DEF_MMIO_BASE,
    parameter logic [31:0] MMIO_MASK      = DEF_MMIO_MASK
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_bus_arbiter_if.master   mmio
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             gnt, gnt_nxt;
    mmio_req_t        req_q, req_nxt;
    mmio_req_t        cand;

    logic             pick;
    logic             pick_valid;

    logic             bus_cs_q, bus_cs_nxt;
    logic             bus_wr_q, bus_wr_nxt;
    logic             bus_rd_q, bus_rd_nxt;
    logic [31:0]      bus_addr_q, bus_addr_nxt;
    logic [31:0]      bus_wdata_q, bus_wdata_nxt;
    logic             m0_ack_q, m0_ack_nxt;
    logic             m1_ack_q, m1_ack_nxt;
    logic [31:0]      m0_rdata_q, m0_rdata_nxt;
    logic [31:0]      m1_rdata_q, m1_rdata_nxt;
    logic             m0_err_q, m0_err_nxt;
    logic             m1_err_q, m1_err_nxt;

    logic             resp_valid;
    logic             resp_sel;
    logic             resp_err;
    logic [31:0]      resp_data;

`ifdef MMIO_ARB_RR_EN
    logic take;
    assign take = (state == ST_IDLE) && pick_valid;

    mmio_rr_picker u_picker (
        .clk   (clk),
        .reset (reset),
        .take  (take),
        .req0  (mmio.m0_req),
        .req1  (mmio.m1_req),
        .pick  (pick),
        .valid (pick_valid)
    );
`else
    mmio_rr_picker u_picker (
        .req0  (mmio.m0_req),
        .req1  (mmio.m1_req),
        .pick  (pick),
        .valid (pick_valid)
    );
`endif

    // Request fields of whichever master the picker currently favours.
    always_comb begin
        cand = '0;
        if (pick) begin
            cand.we    = mmio.m1_we;
            cand.addr  = mmio.m1_addr;
            cand.wdata = mmio.m1_wdata;
        end else begin
            cand.we    = mmio.m0_we;
            cand.addr  = mmio.m0_addr;
            cand.wdata = mmio.m0_wdata;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so every bus/ack output comes straight from a flop.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        req_nxt       = req_q;
        bus_cs_nxt    = 1'b0;
        bus_wr_nxt    = 1'b0;
        bus_rd_nxt    = 1'b0;
        bus_addr_nxt  = '0;
        bus_wdata_nxt = '0;
        resp_valid    = 1'b0;
        resp_sel      = gnt;
        resp_err      = 1'b0;
        resp_data     = '0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_nxt = pick;
                    req_nxt = cand;
                    if (in_window(cand.addr, MMIO_BASE, MMIO_MASK)) begin
                        state_nxt     = ST_BUSY;
                        cnt_nxt       = '0;
                        bus_cs_nxt    = 1'b1;
                        bus_wr_nxt    = cand.we;
                        bus_rd_nxt    = ~cand.we;
                        bus_addr_nxt  = cand.addr;
                        bus_wdata_nxt = cand.wdata;
                    end else begin
                        state_nxt  = ST_RESP;
                        resp_valid = 1'b1;
                        resp_sel   = pick;
                        resp_err   = 1'b1;
                        resp_data  = ERR_DATA;
                    end
                end
            end

            ST_BUSY: begin
                if (mmio.bus_ready) begin
                    state_nxt  = ST_RESP;
                    resp_valid = 1'b1;
                    resp_data  = req_q.we ? '0 : mmio.bus_rd_data;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = ST_RESP;
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    resp_data  = ERR_DATA;
                end else begin
                    cnt_nxt       = cnt + 1'b1;
                    bus_cs_nxt    = 1'b1;
                    bus_wr_nxt    = req_q.we;
                    bus_rd_nxt    = ~req_q.we;
                    bus_addr_nxt  = req_q.addr;
                    bus_wdata_nxt = req_q.wdata;
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        m0_ack_nxt   = resp_valid & ~resp_sel;
        m1_ack_nxt   = resp_valid & resp_sel;
        m0_err_nxt   = m0_ack_nxt & resp_err;
        m1_err_nxt   = m1_ack_nxt & resp_err;
        m0_rdata_nxt = m0_ack_nxt ? resp_data : '0;
        m1_rdata_nxt = m1_ack_nxt ? resp_data : '0;
    end

    // State, sequencing registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            gnt         <= 1'b0;
            req_q       <= '0;
            bus_cs_q    <= 1'b0;
            bus_wr_q    <= 1'b0;
            bus_rd_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            gnt         <= gnt_nxt;
            req_q       <= req_nxt;
            bus_cs_q    <= bus_cs_nxt;
            bus_wr_q    <= bus_wr_nxt;
            bus_rd_q    <= bus_rd_nxt;
            bus_addr_q  <= bus_addr_nxt;
            bus_wdata_q <= bus_wdata_nxt;
            m0_ack_q    <= m0_ack_nxt;
            m1_ack_q    <= m1_ack_nxt;
            m0_rdata_q  <= m0_rdata_nxt;
            m1_rdata_q  <= m1_rdata_nxt;
            m0_err_q    <= m0_err_nxt;
            m1_err_q    <= m1_err_nxt;
        end
    end

    assign mmio.bus_cs      = bus_cs_q;
    assign mmio.bus_wr      = bus_wr_q;
    assign mmio.bus_rd      = bus_rd_q;
    assign mmio.bus_addr    = bus_addr_q;
    assign mmio.bus_wr_data = bus_wdata_q;
    assign mmio.m0_ack      = m0_ack_q;
    assign mmio.m1_ack      = m1_ack_q;
    assign mmio.m0_rdata    = m0_rdata_q;
    assign mmio.m1_rdata    = m1_rdata_q;
    assign mmio.m0_err      = m0_err_q;
    assign mmio.m1_err      = m1_err_q;
    assign mmio.m0_stall    = mmio.m0_req & ~mmio.m0_ack;

endmodule
